// File: rtl/dec_arb.sv
// Four-way round-robin front end for a shared combinational ECC decoder.
// Issues one codeword at a time, holds the response until it is accepted, and keeps saturating error counters.
module dec_arb #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [563:0]     req_data,
    output logic [3:0]       req_ready,
    output logic [140:0]     dec_in,
    input  logic [126:0]     dec_out,
    input  logic [13:0]      dec_syn,
    input  logic             dec_err,
    input  logic             dec_sgl,
    input  logic             dec_dbl,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [1:0]       resp_id,
    output logic [126:0]     resp_data,
    output logic [13:0]      resp_syn,
    output logic             resp_sgl,
    output logic             resp_dbl,
    output logic             resp_unc,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_sgl,
    output logic [CNT_W-1:0] cnt_dbl,
    output logic [CNT_W-1:0] cnt_unc
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 141;

    typedef enum logic [1:0] {
        IDLE,
        DEC,
        HOLD
    } state_t;

    state_t        state;
    logic [1:0]    last_gnt;
    logic [1:0]    gnt_idx;
    logic          gnt_any;
    logic [CW-1:0] sel_data;
    logic          unc;
    logic          inc_sgl;
    logic          inc_dbl;
    logic          inc_unc;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!gnt_any && req_valid[last_gnt + 2'(k)]) begin
                gnt_idx = last_gnt + 2'(k);
                gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        case (gnt_idx)
            2'd0:    sel_data = req_data[0*CW +: CW];
            2'd1:    sel_data = req_data[1*CW +: CW];
            2'd2:    sel_data = req_data[2*CW +: CW];
            default: sel_data = req_data[3*CW +: CW];
        endcase
    end

    // Grant is only offered while idle and out of reset.
    always_comb begin
        req_ready = 4'b0000;
        if (state == IDLE && gnt_any && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign unc     = dec_err & ~dec_sgl & ~dec_dbl;
    assign inc_sgl = (state == DEC) & dec_err & dec_sgl;
    assign inc_dbl = (state == DEC) & dec_err & dec_dbl;
    assign inc_unc = (state == DEC) & unc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_gnt   <= 2'd3;
            dec_in     <= '0;
            resp_id    <= 2'd0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_syn   <= '0;
            resp_sgl   <= 1'b0;
            resp_dbl   <= 1'b0;
            resp_unc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        dec_in   <= sel_data;
                        resp_id  <= gnt_idx;
                        last_gnt <= gnt_idx;
                        state    <= DEC;
                    end
                end
                DEC: begin
                    resp_data  <= dec_out;
                    resp_syn   <= dec_syn;
                    resp_sgl   <= dec_sgl;
                    resp_dbl   <= dec_dbl;
                    resp_unc   <= unc;
                    resp_valid <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating statistics; clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_sgl <= '0;
            cnt_dbl <= '0;
            cnt_unc <= '0;
        end else begin
            if (inc_sgl && cnt_sgl != '1) cnt_sgl <= cnt_sgl + CNT_W'(1);
            if (inc_dbl && cnt_dbl != '1) cnt_dbl <= cnt_dbl + CNT_W'(1);
            if (inc_unc && cnt_unc != '1) cnt_unc <= cnt_unc + CNT_W'(1);
        end
    end

endmodule

// File: doc/dec_arb.md
DEC_ARB -- requirements
Module: dec_arb

Interface
REQ-001 Parameter CNT_W, default 16: width of each error-statistics counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  4  per-requester codeword-valid, bit i = requester i.
REQ-005 req_data  input  564  four 141-bit codewords; requester i occupies bits [141*i+140 : 141*i].
REQ-006 req_ready  output  4  one-hot grant/accept; a codeword is transferred when req_valid[i] and req_ready[i] are both high.
REQ-007 dec_in  output  141  registered codeword driven to the shared combinational decoder.
REQ-008 dec_out  input  127  corrected data from decoder.
REQ-009 dec_syn  input  14  syndrome from decoder.
REQ-010 dec_err, dec_sgl, dec_dbl  input  1 each  decoder error, single-error and double-error flags.
REQ-011 resp_valid  output  1  response valid.
REQ-012 resp_ready  input  1  response consumer ready.
REQ-013 resp_id  output  2  index of the requester that owns the response.
REQ-014 resp_data, resp_syn  output  127, 14  captured dec_out and dec_syn.
REQ-015 resp_sgl, resp_dbl, resp_unc  output  1 each  captured flags; resp_unc = dec_err & ~dec_sgl & ~dec_dbl.
REQ-016 clr_cnt  input  1  synchronous clear of all counters.
REQ-017 cnt_sgl, cnt_dbl, cnt_unc  output  CNT_W each  saturating event counters.

Function
REQ-018 FSM states: IDLE, DEC, HOLD; one codeword in flight at most.
REQ-019 IDLE: if any req_valid, the block grants exactly one requester, asserts its req_ready combinationally in that cycle, loads dec_in with its data and records resp_id, then moves to DEC; if none, it stays in IDLE with req_ready = 0.
REQ-020 req_ready SHALL be 0 in DEC and HOLD regardless of req_valid.
REQ-021 Arbitration is round-robin: priority order is last_gnt+1, last_gnt+2, last_gnt+3, last_gnt (mod 4); last_gnt updates only on a grant.
REQ-022 DEC (one cycle, decoder settle): the block captures dec_out, dec_syn and the flags into the resp_* registers, sets resp_valid = 1 and moves to HOLD.
REQ-023 HOLD: resp_* stay stable while resp_valid = 1; on resp_valid & resp_ready, resp_valid clears next cycle and the FSM moves to IDLE; no grant occurs in that HOLD cycle.
REQ-024 Latency: a grant in cycle T gives resp_valid high in cycle T+2; minimum issue interval is 3 cycles.
REQ-025 dec_in and resp_* retain their last values outside their load cycles.
REQ-026 Counters increment by 1 in the DEC cycle on captured sgl/dbl/unc respectively; at all-ones each counter holds, with no wrap.
REQ-027 clr_cnt has priority: a counter cleared in the same cycle as an increment reads 0 afterwards.
REQ-028 Flags with dec_err = 0 increment no counter; resp_sgl/resp_dbl still mirror the decoder.

Reset
REQ-029 While rst is high at a clock edge: state = IDLE, req_ready = 0, resp_valid = 0, resp_id = 0, resp_data/resp_syn/flags = 0, dec_in = 0, counters = 0, last_gnt = 3 (so requester 0 has first priority).
REQ-030 rst asserted mid-transaction discards the in-flight codeword; no response is produced for it.

Verification
REQ-031 Reset, then req_valid = 4'b0001 with an all-zero codeword -> req_ready = 4'b0001 in the grant cycle; resp_valid two cycles later; resp_id = 0; resp_data = 0; no counter change.
REQ-032 req_valid = 4'b1111 held and resp_ready = 1 -> grants 0,1,2,3,0 in order, each 3 cycles apart.
REQ-033 Decoder model returns sgl, then dbl, then err-only -> cnt_sgl = 1, cnt_dbl = 1, cnt_unc = 1, resp_unc = 1 on the third response only.
REQ-034 resp_ready held low for 10 cycles -> resp_* stable, req_ready = 0 throughout, no new grant until the cycle after the handshake.
REQ-035 cnt_sgl preloaded to 0xFFFF by repeated single errors -> stays 0xFFFF; clr_cnt coincident with a sgl capture -> cnt_sgl = 0.
REQ-036 rst pulsed in the DEC cycle -> resp_valid never rises, next grant goes to requester 0.
